// File: rtl/attosoc_gpio_pkg.sv
// Shared constants for the attosoc GPIO block: bus widths, register offsets, lane mask helper.
package attosoc_gpio_pkg;

  localparam int unsigned BUS_AW = 32;
  localparam int unsigned BUS_DW = 32;
  localparam int unsigned BUS_SW = BUS_DW / 8;
  localparam int unsigned IDX_W  = 6;

  // Byte offsets inside the 256-byte window (shared with firmware headers).
  localparam logic [7:0] GPIO_OFF_OUT  = 8'h00;
  localparam logic [7:0] GPIO_OFF_SET  = 8'h04;
  localparam logic [7:0] GPIO_OFF_CLR  = 8'h08;
  localparam logic [7:0] GPIO_OFF_TGL  = 8'h0C;
  localparam logic [7:0] GPIO_OFF_DIR  = 8'h10;
  localparam logic [7:0] GPIO_OFF_IN   = 8'h14;
  localparam logic [7:0] GPIO_OFF_RISE = 8'h18;
  localparam logic [7:0] GPIO_OFF_FALL = 8'h1C;
  localparam logic [7:0] GPIO_OFF_IE   = 8'h20;

  // Word indices as decoded from mem_addr[7:2].
  localparam logic [IDX_W-1:0] IDX_OUT  = GPIO_OFF_OUT[7:2];
  localparam logic [IDX_W-1:0] IDX_SET  = GPIO_OFF_SET[7:2];
  localparam logic [IDX_W-1:0] IDX_CLR  = GPIO_OFF_CLR[7:2];
  localparam logic [IDX_W-1:0] IDX_TGL  = GPIO_OFF_TGL[7:2];
  localparam logic [IDX_W-1:0] IDX_DIR  = GPIO_OFF_DIR[7:2];
  localparam logic [IDX_W-1:0] IDX_IN   = GPIO_OFF_IN[7:2];
  localparam logic [IDX_W-1:0] IDX_RISE = GPIO_OFF_RISE[7:2];
  localparam logic [IDX_W-1:0] IDX_FALL = GPIO_OFF_FALL[7:2];
  localparam logic [IDX_W-1:0] IDX_IE   = GPIO_OFF_IE[7:2];

  // Expand byte strobes into a per-bit mask.
  function automatic logic [BUS_DW-1:0] strb_mask(input logic [BUS_SW-1:0] wstrb);
    logic [BUS_DW-1:0] m;
    m = '0;
    for (int i = 0; i < int'(BUS_SW); i++) begin
      m[i*8 +: 8] = {8{wstrb[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/attosoc_gpio_if.sv
// PicoRV32 native memory bus, as seen by one peripheral window.
interface attosoc_gpio_if;
  import attosoc_gpio_pkg::*;

  logic              mem_valid;
  logic [BUS_AW-1:0] mem_addr;
  logic [BUS_DW-1:0] mem_wdata;
  logic [BUS_SW-1:0] mem_wstrb;
  logic              mem_ready;
  logic [BUS_DW-1:0] mem_rdata;

  modport master (
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );

endinterface

// File: rtl/attosoc_gpio_sync.sv
// Input synchroniser plus one delayed copy for rising/falling edge detection.
module attosoc_gpio_sync #(
  parameter int unsigned GPIO_WIDTH  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [GPIO_WIDTH-1:0] gpio_in,
  output logic [GPIO_WIDTH-1:0] in_q,
  output logic [GPIO_WIDTH-1:0] rise_c,
  output logic [GPIO_WIDTH-1:0] fall_c
);

  logic [GPIO_WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [GPIO_WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [GPIO_WIDTH-1:0] prev_q;
  logic [GPIO_WIDTH-1:0] prev_d;

  // Shift chain: pins enter stage 0, the last stage feeds the edge-detect copy.
  always_comb begin
    sync_d[0] = gpio_in;
    for (int i = 1; i < int'(SYNC_STAGES); i++) begin
      sync_d[i] = sync_q[i-1];
    end
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // Chain clears on reset, so a pin held high produces one rise after release.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= '0;
      end
      prev_q <= '0;
    end else begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= sync_d[i];
      end
      prev_q <= prev_d;
    end
  end

  assign in_q   = sync_q[SYNC_STAGES-1];
  assign rise_c = in_q & ~prev_q;
  assign fall_c = ~in_q & prev_q;

endmodule

// File: rtl/attosoc_gpio.sv
// Memory-mapped GPIO: OUT/DIR/IE registers, set/clear/toggle aliases, edge status, level irq.
module attosoc_gpio
  import attosoc_gpio_pkg::*;
#(
  parameter int unsigned           GPIO_WIDTH  = 8,
  parameter logic [BUS_AW-1:0]     BASE_ADDR   = 32'h0200_0000,
  parameter logic [GPIO_WIDTH-1:0] OUT_RESET   = '0,
  parameter logic [GPIO_WIDTH-1:0] DIR_RESET   = '1,
  parameter int unsigned           SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  attosoc_gpio_if.slave         bus,
  input  logic [GPIO_WIDTH-1:0] gpio_in,
  output logic [GPIO_WIDTH-1:0] gpio_out,
  output logic [GPIO_WIDTH-1:0] gpio_oe,
  output logic                  irq
);

  localparam int unsigned W = GPIO_WIDTH;

  logic [W-1:0]      out_q, out_d;
  logic [W-1:0]      dir_q, dir_d;
  logic [W-1:0]      ie_q, ie_d;
  logic [W-1:0]      rise_q, rise_d;
  logic [W-1:0]      fall_q, fall_d;
  logic              ready_q, ready_d;
  logic [BUS_DW-1:0] rdata_q, rdata_d;
  logic              irq_q, irq_d;

  logic [W-1:0]      in_q;
  logic [W-1:0]      edge_rise_c;
  logic [W-1:0]      edge_fall_c;

  logic              sel_c;
  logic              accept_c;
  logic              wr_c;
  logic [IDX_W-1:0]  idx_c;
  logic [BUS_DW-1:0] mask_full_c;
  logic [BUS_DW-1:0] data_full_c;
  logic [W-1:0]      mask_c;
  logic [W-1:0]      data_c;
  logic [W-1:0]      w1c_rise_c;
  logic [W-1:0]      w1c_fall_c;
  logic [BUS_DW-1:0] rd_c;
  logic              unused_c;

  attosoc_gpio_sync #(
    .GPIO_WIDTH  (W),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .gpio_in (gpio_in),
    .in_q    (in_q),
    .rise_c  (edge_rise_c),
    .fall_c  (edge_fall_c)
  );

  // Window decode; an access is accepted once, on the cycle before ready.
  assign sel_c       = bus.mem_valid && (bus.mem_addr[31:8] == BASE_ADDR[31:8]);
  assign accept_c    = sel_c && !ready_q;
  assign wr_c        = accept_c && (|bus.mem_wstrb);
  assign idx_c       = bus.mem_addr[7:2];
  assign mask_full_c = strb_mask(bus.mem_wstrb);
  assign data_full_c = bus.mem_wdata & mask_full_c;
  assign mask_c      = mask_full_c[W-1:0];
  assign data_c      = data_full_c[W-1:0];

  // Byte-address LSBs and lanes above the pin count carry no state.
  assign unused_c = ^{bus.mem_addr[1:0], mask_full_c, data_full_c};

  // Read mux over the register map; unmapped offsets read zero.
  always_comb begin
    rd_c = '0;
    case (idx_c)
      IDX_OUT, IDX_SET, IDX_CLR, IDX_TGL: rd_c = BUS_DW'(out_q);
      IDX_DIR:                            rd_c = BUS_DW'(dir_q);
      IDX_IN:                             rd_c = BUS_DW'(in_q);
      IDX_RISE:                           rd_c = BUS_DW'(rise_q);
      IDX_FALL:                           rd_c = BUS_DW'(fall_q);
      IDX_IE:                             rd_c = BUS_DW'(ie_q);
      default:                            rd_c = '0;
    endcase
  end

  // Next-state: register writes, edge status with set-over-clear, handshake, irq.
  always_comb begin
    out_d      = out_q;
    dir_d      = dir_q;
    ie_d       = ie_q;
    w1c_rise_c = '0;
    w1c_fall_c = '0;
    if (wr_c) begin
      case (idx_c)
        IDX_OUT:  out_d      = (out_q & ~mask_c) | data_c;
        IDX_SET:  out_d      = out_q | data_c;
        IDX_CLR:  out_d      = out_q & ~data_c;
        IDX_TGL:  out_d      = out_q ^ data_c;
        IDX_DIR:  dir_d      = (dir_q & ~mask_c) | data_c;
        IDX_RISE: w1c_rise_c = data_c;
        IDX_FALL: w1c_fall_c = data_c;
        IDX_IE:   ie_d       = (ie_q & ~mask_c) | data_c;
        default:  ;
      endcase
    end
    rise_d  = (rise_q & ~w1c_rise_c) | edge_rise_c;
    fall_d  = (fall_q & ~w1c_fall_c) | edge_fall_c;
    irq_d   = |((rise_q | fall_q) & ie_q);
    ready_d = accept_c;
    rdata_d = accept_c ? rd_c : '0;
  end

  // State registers; reset abandons any in-flight access.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_q   <= OUT_RESET;
      dir_q   <= DIR_RESET;
      ie_q    <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      ready_q <= 1'b0;
      rdata_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      out_q   <= out_d;
      dir_q   <= dir_d;
      ie_q    <= ie_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      irq_q   <= irq_d;
    end
  end

  assign bus.mem_ready = ready_q;
  assign bus.mem_rdata = rdata_q;
  assign gpio_out      = out_q;
  assign gpio_oe       = dir_q;
  assign irq           = irq_q;

endmodule

// File: tb/tb_attosoc_gpio.sv
// Directed bench for attosoc_gpio: an 8-pin instance for the main map, a 32-pin one for lanes.
module tb_attosoc_gpio;
  import attosoc_gpio_pkg::*;

  localparam logic [31:0] BASE = 32'h0200_0000;

  logic        clk;
  logic        reset_n;
  logic [7:0]  gpio_in8;
  logic [7:0]  gpio_out8;
  logic [7:0]  gpio_oe8;
  logic        irq8;
  logic [31:0] gpio_in32;
  logic [31:0] gpio_out32;
  logic [31:0] gpio_oe32;
  logic        irq32;

  int n_cmp;
  int n_err;
  logic [31:0] rd;
  int seen;

  attosoc_gpio_if bus8 ();
  attosoc_gpio_if bus32 ();

  attosoc_gpio #(.GPIO_WIDTH(8)) u_dut8 (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus8),
    .gpio_in  (gpio_in8),
    .gpio_out (gpio_out8),
    .gpio_oe  (gpio_oe8),
    .irq      (irq8)
  );

  attosoc_gpio #(.GPIO_WIDTH(32)) u_dut32 (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus32),
    .gpio_in  (gpio_in32),
    .gpio_out (gpio_out32),
    .gpio_oe  (gpio_oe32),
    .irq      (irq32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One access on the 8-pin bus; valid is held through the ready cycle and one more.
  task automatic xfer(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] wstrb, output logic [31:0] rdata);
    int lat;
    lat   = -1;
    rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    bus8.mem_valid = 1'b1;
    bus8.mem_addr  = addr;
    bus8.mem_wdata = wdata;
    bus8.mem_wstrb = wstrb;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (bus8.mem_ready === 1'b1) begin
        lat   = i;
        rdata = bus8.mem_rdata;
        break;
      end
    end
    chk({tag, "_lat"}, 32'(lat), 32'd0);
    @(posedge clk);
    #1;
    chk({tag, "_pulse"}, {30'd0, bus8.mem_ready, |bus8.mem_rdata}, 32'd0);
    bus8.mem_valid = 1'b0;
    bus8.mem_wstrb = 4'h0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset_n = 1'b0;
    gpio_in8 = 8'h00;
    gpio_in32 = 32'h0;
    bus8.mem_valid = 1'b0;
    bus8.mem_addr = 32'h0;
    bus8.mem_wdata = 32'h0;
    bus8.mem_wstrb = 4'h0;
    bus32.mem_valid = 1'b0;
    bus32.mem_addr = 32'h0;
    bus32.mem_wdata = 32'h0;
    bus32.mem_wstrb = 4'h0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", 32'(gpio_out8), 32'h00);
    chk("rst_oe", 32'(gpio_oe8), 32'hFF);
    chk("rst_irq", 32'(irq8), 32'h0);
    chk("rst_ready", 32'(bus8.mem_ready), 32'h0);
    chk("rst_rdata", bus8.mem_rdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    xfer("rd_out", BASE | 32'(GPIO_OFF_OUT), 32'h0, 4'h0, rd);
    chk("rd_out_val", rd, 32'h00);
    xfer("rd_dir", BASE | 32'(GPIO_OFF_DIR), 32'h0, 4'h0, rd);
    chk("rd_dir_val", rd, 32'hFF);
    xfer("rd_ie", BASE | 32'(GPIO_OFF_IE), 32'h0, 4'h0, rd);
    chk("rd_ie_val", rd, 32'h00);

    // OUT and its atomic aliases.
    xfer("wr_out", BASE | 32'(GPIO_OFF_OUT), 32'hA5, 4'hF, rd);
    chk("out_a5", 32'(gpio_out8), 32'hA5);
    xfer("wr_set", BASE | 32'(GPIO_OFF_SET), 32'h0A, 4'hF, rd);
    chk("out_af", 32'(gpio_out8), 32'hAF);
    xfer("wr_clr", BASE | 32'(GPIO_OFF_CLR), 32'h81, 4'hF, rd);
    chk("out_2e", 32'(gpio_out8), 32'h2E);
    xfer("wr_tgl", BASE | 32'(GPIO_OFF_TGL), 32'hFF, 4'hF, rd);
    chk("out_d1", 32'(gpio_out8), 32'hD1);
    xfer("wr_lane", BASE | 32'(GPIO_OFF_OUT), 32'hFFFF_FF00, 4'b1110, rd);
    chk("out_lane", 32'(gpio_out8), 32'hD1);
    xfer("rd_tgl", BASE | 32'(GPIO_OFF_TGL), 32'h0, 4'h0, rd);
    chk("rd_tgl_val", rd, 32'hD1);

    // Byte-lane write on the 32-pin instance.
    @(negedge clk);
    bus32.mem_valid = 1'b1;
    bus32.mem_addr  = BASE | 32'(GPIO_OFF_OUT);
    bus32.mem_wdata = 32'h1234_5678;
    bus32.mem_wstrb = 4'b0001;
    @(posedge clk);
    #1;
    chk("b32_ready", 32'(bus32.mem_ready), 32'h1);
    bus32.mem_valid = 1'b0;
    bus32.mem_wstrb = 4'h0;
    @(posedge clk);
    #1;
    chk("b32_out", gpio_out32, 32'h0000_0078);
    chk("b32_oe", gpio_oe32, 32'hFFFF_FFFF);

    // Rising edge on pin 3 with IE bit 3: irq SYNC_STAGES+2 cycles later.
    xfer("wr_ie", BASE | 32'(GPIO_OFF_IE), 32'h08, 4'hF, rd);
    chk("irq_idle", 32'(irq8), 32'h0);
    @(negedge clk);
    gpio_in8 = 8'h08;
    repeat (3) @(posedge clk);
    #1;
    chk("irq_early", 32'(irq8), 32'h0);
    @(posedge clk);
    #1;
    chk("irq_rise", 32'(irq8), 32'h1);
    xfer("rd_rise", BASE | 32'(GPIO_OFF_RISE), 32'h0, 4'h0, rd);
    chk("rise_08", rd, 32'h08);
    xfer("rd_in", BASE | 32'(GPIO_OFF_IN), 32'h0, 4'h0, rd);
    chk("in_08", rd, 32'h08);
    xfer("rd_fall0", BASE | 32'(GPIO_OFF_FALL), 32'h0, 4'h0, rd);
    chk("fall_00", rd, 32'h00);

    @(negedge clk);
    gpio_in8 = 8'h00;
    repeat (4) @(posedge clk);
    xfer("rd_fall1", BASE | 32'(GPIO_OFF_FALL), 32'h0, 4'h0, rd);
    chk("fall_08", rd, 32'h08);
    xfer("w1c_rise", BASE | 32'(GPIO_OFF_RISE), 32'h08, 4'hF, rd);
    chk("irq_fall_held", 32'(irq8), 32'h1);
    xfer("w1c_fall", BASE | 32'(GPIO_OFF_FALL), 32'h08, 4'hF, rd);
    chk("irq_cleared", 32'(irq8), 32'h0);
    xfer("rd_rise2", BASE | 32'(GPIO_OFF_RISE), 32'h0, 4'h0, rd);
    chk("rise_clr", rd, 32'h00);
    xfer("rd_fall2", BASE | 32'(GPIO_OFF_FALL), 32'h0, 4'h0, rd);
    chk("fall_clr", rd, 32'h00);

    // Edge on pin 2 lands in the same cycle the W1C of RISE[2] commits.
    @(negedge clk);
    gpio_in8 = 8'h04;
    @(posedge clk);
    @(posedge clk);
    xfer("w1c_race", BASE | 32'(GPIO_OFF_RISE), 32'h04, 4'hF, rd);
    xfer("rd_race", BASE | 32'(GPIO_OFF_RISE), 32'h0, 4'h0, rd);
    chk("rise_set_wins", rd, 32'h04);
    chk("irq_masked", 32'(irq8), 32'h0);

    // Unmapped offsets.
    xfer("rd_40", BASE | 32'h40, 32'h0, 4'h0, rd);
    chk("rd_40_val", rd, 32'h0);
    xfer("wr_fc", BASE | 32'hFC, 32'hFFFF_FFFF, 4'hF, rd);
    chk("fc_out", 32'(gpio_out8), 32'hD1);
    chk("fc_oe", 32'(gpio_oe8), 32'hFF);
    xfer("rd_ie2", BASE | 32'(GPIO_OFF_IE), 32'h0, 4'h0, rd);
    chk("ie_kept", rd, 32'h08);

    xfer("wr_dir", BASE | 32'(GPIO_OFF_DIR), 32'h0F, 4'hF, rd);
    chk("oe_0f", 32'(gpio_oe8), 32'h0F);

    // Outside the window: no ready, no side effect.
    @(negedge clk);
    bus8.mem_valid = 1'b1;
    bus8.mem_addr  = 32'h0200_0100;
    bus8.mem_wdata = 32'h0;
    bus8.mem_wstrb = 4'hF;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (bus8.mem_ready === 1'b1) seen++;
    end
    bus8.mem_valid = 1'b0;
    bus8.mem_wstrb = 4'h0;
    chk("oow_ready", 32'(seen), 32'd0);
    chk("oow_out", 32'(gpio_out8), 32'hD1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/attosoc_gpio.md
Name: attosoc_gpio

Overview:
- Parametrised successor to the single fixed 8-bit LED register: a memory-mapped GPIO peripheral on the PicoRV32 native memory bus.
- Adds per-pin direction, atomic set/clear/toggle aliases, synchronised inputs, rising/falling edge capture with write-1-to-clear, and a level interrupt output.
- Sits beside simpleuart in the SoC I/O region and drives mem_ready/mem_rdata for its own 256-byte window.

Parameters:
GPIO_WIDTH, 8, number of pins, 1..32
BASE_ADDR, 32'h0200_0000, window base; only bits [31:8] are compared
OUT_RESET, 0, OUT register reset value (GPIO_WIDTH bits)
DIR_RESET, all ones, DIR register reset value (1 = output)
SYNC_STAGES, 2, input synchroniser depth, 2..3

Ports:
clk  in  1  clock
reset_n  in  1  synchronous, active-low reset, sampled on posedge clk
mem_valid  in  1  CPU access request
mem_addr  in  32  byte address
mem_wdata  in  32  write data
mem_wstrb  in  4  byte write strobes; all zero = read
mem_ready  out  1  access complete, one-cycle pulse
mem_rdata  out  32  read data, valid while mem_ready=1
gpio_in  in  GPIO_WIDTH  asynchronous pin inputs
gpio_out  out  GPIO_WIDTH  OUT register
gpio_oe  out  GPIO_WIDTH  DIR register, pin drive enable
irq  out  1  level interrupt

Behaviour:
- sel = mem_valid && mem_addr[31:8] == BASE_ADDR[31:8]; offset = mem_addr[7:2].
- Handshake:
  - mem_ready is registered: mem_ready <= sel && !mem_ready.
  - Fixed latency is 1 cycle. Ready is one cycle wide and never on two consecutive cycles.
  - Writes commit on the accept cycle (sel && !mem_ready), so each access has exactly one side effect.
- mem_rdata is registered on the accept cycle and is 0 whenever mem_ready=0. Unused upper bits read 0.
- Register map (byte offset):
  - 0x00 OUT: rw.
  - 0x04 SET: write OUT |= d; reads OUT.
  - 0x08 CLR: write OUT &= ~d; reads OUT.
  - 0x0C TGL: write OUT ^= d; reads OUT.
  - 0x10 DIR: rw.
  - 0x14 IN: ro, synchronised pins.
  - 0x18 RISE: status, W1C.
  - 0x1C FALL: status, W1C.
  - 0x20 IE: rw, per-pin interrupt enable.
  - Other offsets: read 0, writes ignored, ready still returned (no bus hang).
- Byte lanes: for every register, d = mem_wdata masked by mem_wstrb per byte. Lanes with strobe 0 leave their bits unchanged (for SET/CLR/TGL/W1C the masked lanes are treated as 0).
- Inputs:
  - gpio_in passes through SYNC_STAGES flops, giving IN.
  - One further delayed copy, prev, is used for edge detection.
  - rise = IN & ~prev; fall = ~IN & prev.
  - Edge detection runs on all pins regardless of DIR.
- Status:
  - RISE <= (RISE & ~w1c) | rise, and likewise FALL.
  - A new edge in the same cycle as W1C of that bit: set wins, so the bit stays 1.
- irq = |((RISE | FALL) & IE), registered. Latency from gpio_in edge to irq is SYNC_STAGES+2 cycles.
- Reset (reset_n=0 at posedge):
  - OUT=OUT_RESET, DIR=DIR_RESET, IE=0, RISE=FALL=0.
  - Sync and prev flops = 0.
  - mem_ready=0, mem_rdata=0, irq=0.
- Reset mid-access:
  - Ready is suppressed and no write commits.
  - The CPU is also in reset, so the access is abandoned.
- Sync flops clear to 0 on reset. A pin held high through reset therefore produces exactly one RISE event after reset release. This is intended, and firmware clears RISE at boot.

Decomposition:
- Shared package/header: register offset constants (GPIO_OFF_OUT..GPIO_OFF_IE) and a byte-strobe mask helper function, so firmware headers and the bench share one source.
- One sub-module: attosoc_gpio_sync, parametrised by GPIO_WIDTH and SYNC_STAGES. Outputs IN, rise and fall. Resets with the parent.

Test Plan:
- Reset, then read 0x00, 0x10, 0x20 -> 0x00, 0xFF, 0x00. mem_ready is high exactly 1 cycle after mem_valid, one-cycle pulse.
- Write OUT=0xA5, then SET 0x0A, CLR 0x81, TGL 0xFF -> gpio_out sequence 0xA5, 0xAF, 0x2E, 0xD1.
- Write 0x12345678 to OUT with wstrb=4'b0001 (GPIO_WIDTH=32, OUT=0) -> OUT=0x00000078.
- gpio_in[3] 0->1->0 with IE=0x08 -> RISE=0x08 and irq=1 SYNC_STAGES+2 cycles after the rising edge; FALL=0x08 after the fall. W1C 0x08 to RISE and FALL -> irq=0 next cycle.
- Apply a rising edge on pin 2 in the same cycle as a W1C of RISE bit 2 commits -> RISE[2] remains 1.
- Read offset 0x40 and write offset 0xFC -> rdata 0, ready returned, no register changes. Access at 0x0200_0100 (outside window) -> no mem_ready from this block.
